// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte with ACK
// handling, and STOP. SDA is an open-drain enable; SCL timing uses a quarter-period divider.
module i2c_master_byte #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   input  logic       sda_in,
   output logic       scl,
   output logic       sda_oe,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic [7:0] rdata
);

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] QMAX  = QW'(CLK_DIV - 1);
   localparam logic [QW-1:0] QONE  = QW'(1);
   localparam logic [QW-1:0] QZERO = QW'(0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_ACK1  = 3'd3,
      ST_WDATA = 3'd4,
      ST_RDATA = 3'd5,
      ST_ACK2  = 3'd6,
      ST_STOP  = 3'd7
   } state_t;

   state_t        state_r, state_s;
   logic [QW-1:0] qcnt_r, qcnt_s;
   logic [1:0]    qidx_r, qidx_s;
   logic [2:0]    bit_r, bit_s;
   logic [7:0]    abyte_r, wbyte_r, shift_r, rdata_r;
   logic          busy_r, done_r, nack_r, scl_r, oe_r;
   logic          accept_s, finish_s, sample_s, scl_s, oe_s;

   // sda_in is sampled on the last system clock of quarter 2 (SCL high).
   assign sample_s = (state_r != ST_IDLE) && (qcnt_r == QMAX) && (qidx_r == 2'd2);

   // Next-state logic: quarter/bit counters and slot-end transitions.
   always_comb begin
      state_s  = state_r;
      qcnt_s   = qcnt_r;
      qidx_s   = qidx_r;
      bit_s    = bit_r;
      accept_s = 1'b0;
      finish_s = 1'b0;
      if (state_r == ST_IDLE) begin
         // The done cycle is still IDLE, but a start there must wait one more cycle.
         if (start && !done_r) begin
            accept_s = 1'b1;
            state_s  = ST_START;
            qcnt_s   = QZERO;
            qidx_s   = 2'd0;
            bit_s    = 3'd0;
         end else begin
            state_s = ST_IDLE;
         end
      end else if (qcnt_r != QMAX) begin
         qcnt_s = qcnt_r + QONE;
      end else begin
         qcnt_s = QZERO;
         qidx_s = qidx_r + 2'd1;
         if (qidx_r == 2'd3) begin
            case (state_r)
               ST_START: begin
                  state_s = ST_ADDR;
                  bit_s   = 3'd0;
               end
               ST_ADDR, ST_WDATA, ST_RDATA: begin
                  if (bit_r == 3'd7) begin
                     state_s = (state_r == ST_ADDR) ? ST_ACK1 : ST_ACK2;
                     bit_s   = 3'd0;
                  end else begin
                     bit_s = bit_r + 3'd1;
                  end
               end
               ST_ACK1: begin
                  if (nack_r) begin
                     state_s = ST_STOP;
                  end else if (abyte_r[0]) begin
                     state_s = ST_RDATA;
                  end else begin
                     state_s = ST_WDATA;
                  end
               end
               ST_ACK2: state_s = ST_STOP;
               ST_STOP: begin
                  state_s  = ST_IDLE;
                  finish_s = 1'b1;
               end
               default: state_s = ST_IDLE;
            endcase
         end else begin
            state_s = state_r;
         end
      end
   end

   // Bus levels for the quarter being entered; registered so outputs have no input path.
   always_comb begin
      scl_s = 1'b1;
      oe_s  = 1'b0;
      case (state_s)
         ST_IDLE: begin
            scl_s = 1'b1;
            oe_s  = 1'b0;
         end
         ST_START: begin
            scl_s = 1'b1;
            oe_s  = qidx_s[1];
         end
         ST_ADDR: begin
            scl_s = qidx_s[1];
            oe_s  = ~abyte_r[3'd7 - bit_s];
         end
         ST_WDATA: begin
            scl_s = qidx_s[1];
            oe_s  = ~wbyte_r[3'd7 - bit_s];
         end
         ST_ACK1, ST_RDATA, ST_ACK2: begin
            scl_s = qidx_s[1];
            oe_s  = 1'b0;
         end
         ST_STOP: begin
            scl_s = qidx_s[1];
            oe_s  = (qidx_s != 2'd3);
         end
         default: begin
            scl_s = 1'b1;
            oe_s  = 1'b0;
         end
      endcase
   end

   // State, counters, captured request, sampled bits and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         qcnt_r  <= QZERO;
         qidx_r  <= 2'd0;
         bit_r   <= 3'd0;
         abyte_r <= 8'd0;
         wbyte_r <= 8'd0;
         shift_r <= 8'd0;
         rdata_r <= 8'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         nack_r  <= 1'b0;
         scl_r   <= 1'b1;
         oe_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         qcnt_r  <= qcnt_s;
         qidx_r  <= qidx_s;
         bit_r   <= bit_s;
         scl_r   <= scl_s;
         oe_r    <= oe_s;
         done_r  <= finish_s;
         if (accept_s) begin
            abyte_r <= {addr, rw};
            wbyte_r <= wdata;
            nack_r  <= 1'b0;
            busy_r  <= 1'b1;
         end else if (finish_s) begin
            busy_r <= 1'b0;
            // A read that lost its address ACK keeps the previous rdata.
            if (abyte_r[0] && !nack_r) begin
               rdata_r <= shift_r;
            end
         end
         if (sample_s) begin
            case (state_r)
               ST_ACK1: begin
                  if (sda_in) begin
                     nack_r <= 1'b1;
                  end
               end
               ST_ACK2: begin
                  if (!abyte_r[0] && sda_in) begin
                     nack_r <= 1'b1;
                  end
               end
               ST_RDATA: shift_r <= {shift_r[6:0], sda_in};
               default: ;
            endcase
         end
      end
   end

   assign scl    = scl_r;
   assign sda_oe = oe_r;
   assign busy   = busy_r;
   assign done   = done_r;
   assign nack   = nack_r;
   assign rdata  = rdata_r;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Scoreboard bench for i2c_master_byte: a bus-slave model answers ACK/read slots,
// a monitor records SCL-rising SDA levels and checks each completed transaction.
module tb_i2c_master_byte;

   localparam int CLK_DIV = 4;

   logic       clk, rst, start, rw, sda_in, scl, sda_oe, busy, done, nack;
   logic [6:0] addr;
   logic [7:0] wdata, rdata;

   i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .rw     (rw),
      .addr   (addr),
      .wdata  (wdata),
      .sda_in (sda_in),
      .scl    (scl),
      .sda_oe (sda_oe),
      .busy   (busy),
      .done   (done),
      .nack   (nack),
      .rdata  (rdata)
   );

   typedef struct {
      int          done_cyc;
      logic        nack;
      logic [7:0]  rd;
      logic [18:0] bits;
      int          nbits;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          fails = 0;
   int          cyc = 0;
   int          slot = 99;
   int          rises = 0;
   int          obs_n = 0;
   logic [18:0] obs_bits = 19'd0;
   logic        ack2_oe = 1'b0;
   logic        busy_q = 1'b0, scl_q = 1'b1, done_q = 1'b0;
   logic        cfg_rw = 1'b0, cfg_ack1 = 1'b0, cfg_ack2 = 1'b0;
   logic [7:0]  cfg_rbyte = 8'd0;
   logic [2:0]  ridx;
   logic        slave_low;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: slot 8 = ACK1, slots 9..16 = data, slot 17 = ACK2.
   always_comb begin
      ridx      = 3'(16 - slot);
      slave_low = 1'b0;
      if (slot == 8) slave_low = cfg_ack1;
      else if (slot == 17) slave_low = cfg_ack2;
      else if (cfg_rw && slot >= 9 && slot <= 16) slave_low = ~cfg_rbyte[ridx];
      else slave_low = 1'b0;
   end

   assign sda_in = ~(sda_oe | slave_low);

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy && !busy_q) begin
            rises    = 0;
            slot     = 99;
            obs_bits = 19'd0;
            obs_n    = 0;
            ack2_oe  = 1'b0;
         end
         if (busy) begin
            if (scl && !scl_q) begin
               obs_bits = {obs_bits[17:0], sda_in};
               obs_n++;
               rises++;
            end
            if (!scl && scl_q) slot = rises;
            if (slot == 17 && sda_oe) ack2_oe = 1'b1;
         end
         if (done) begin
            cmp("done_pulse_width", 32'(done_q), 32'd0);
            cmp("sb_nonempty_at_done", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               cmp("done_cycle", 32'(cyc), 32'(e.done_cyc));
               cmp("nack", 32'(nack), 32'(e.nack));
               cmp("rdata", 32'(rdata), 32'(e.rd));
               cmp("sda_bits", 32'(obs_bits), 32'(e.bits));
               cmp("sda_bit_count", 32'(obs_n), 32'(e.nbits));
               cmp("oe_in_ack2", 32'(ack2_oe), 32'd0);
               cmp("busy_at_done", 32'(busy), 32'd0);
            end
         end
         busy_q = busy;
         scl_q  = scl;
         done_q = done;
      end
   endtask

   // Drives a start at the current negedge; lat = edges until acceptance is expected.
   task automatic issue(input logic i_rw, input logic [6:0] i_addr, input logic [7:0] i_wdata,
                        input logic a1, input logic a2, input logic [7:0] rb, input int lat,
                        input bit push, input int nq, input logic [18:0] eb, input int en,
                        input logic en_nack, input logic [7:0] erd);
      exp_t e;
      int   c0;
      bit   seen;
      c0        = cyc;
      cfg_rw    = i_rw;
      cfg_ack1  = a1;
      cfg_ack2  = a2;
      cfg_rbyte = rb;
      rw        = i_rw;
      addr      = i_addr;
      wdata     = i_wdata;
      start     = 1'b1;
      if (push) begin
         e.done_cyc = c0 + lat + nq * CLK_DIV;
         e.nack     = en_nack;
         e.rd       = erd;
         e.bits     = eb;
         e.nbits    = en;
         sb.push_back(e);
      end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      start = 1'b0;
      cmp("accept_seen", 32'(seen), 32'd1);
      cmp("accept_cycle", 32'(cyc), 32'(c0 + lat));
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      cmp("done_within_budget", 32'(seen), 32'd1);
   endtask

   initial begin
      bit seen;
      rst   = 1'b0;
      start = 1'b0;
      rw    = 1'b0;
      addr  = 7'd0;
      wdata = 8'd0;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      cmp("reset_scl", 32'(scl), 32'd1);
      cmp("reset_sda_oe", 32'(sda_oe), 32'd0);
      cmp("reset_busy", 32'(busy), 32'd0);
      cmp("reset_done", 32'(done), 32'd0);
      cmp("reset_nack", 32'(nack), 32'd0);
      cmp("reset_rdata", 32'(rdata), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Write 0x50 <- 0xA5, both ACKed.
      issue(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1, 1'b1, 80,
            {8'b1010_0000, 1'b0, 8'b1010_0101, 1'b0, 1'b0}, 19, 1'b0, 8'h00);
      wait_done();
      @(negedge clk);

      // Read 0x50, slave returns 0x3C; master NACKs the data byte.
      issue(1'b1, 7'h50, 8'h00, 1'b1, 1'b0, 8'h3C, 1, 1'b1, 80,
            {8'b1010_0001, 1'b0, 8'b0011_1100, 1'b1, 1'b0}, 19, 1'b0, 8'h3C);
      wait_done();
      @(negedge clk);

      // Address NACK: no data slots, straight to STOP; rdata held.
      issue(1'b0, 7'h2A, 8'hFF, 1'b0, 1'b0, 8'h00, 1, 1'b1, 44,
            {9'd0, 8'b0101_0100, 1'b1, 1'b0}, 10, 1'b1, 8'h3C);
      wait_done();
      @(negedge clk);

      // Write data NACK.
      issue(1'b0, 7'h50, 8'h3C, 1'b1, 1'b0, 8'h00, 1, 1'b1, 80,
            {8'b1010_0000, 1'b0, 8'b0011_1100, 1'b1, 1'b0}, 19, 1'b1, 8'h3C);
      wait_done();

      // Back-to-back: start raised in the done cycle is accepted one cycle later.
      issue(1'b1, 7'h23, 8'h00, 1'b1, 1'b0, 8'hC5, 2, 1'b1, 80,
            {8'b0100_0111, 1'b0, 8'b1100_0101, 1'b1, 1'b0}, 19, 1'b0, 8'hC5);
      cmp("nack_cleared_on_start", 32'(nack), 32'd0);
      wait_done();
      @(negedge clk);

      // Start while busy with different request fields must not disturb the transfer.
      issue(1'b0, 7'h50, 8'h5A, 1'b1, 1'b1, 8'h00, 1, 1'b1, 80,
            {8'b1010_0000, 1'b0, 8'b0101_1010, 1'b0, 1'b0}, 19, 1'b0, 8'hC5);
      repeat (150) @(negedge clk);
      addr  = 7'h11;
      rw    = 1'b1;
      wdata = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);

      // Reset during address bit 3 releases the bus without a clock edge.
      issue(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1, 1'b0, 80, 19'd0, 0, 1'b0, 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (slot == 3) seen = 1'b1;
      end
      cmp("reached_addr_bit3", 32'(seen), 32'd1);
      #2 rst = 1'b0;
      #1;
      cmp("async_rst_scl", 32'(scl), 32'd1);
      cmp("async_rst_sda_oe", 32'(sda_oe), 32'd0);
      cmp("async_rst_busy", 32'(busy), 32'd0);
      cmp("async_rst_rdata", 32'(rdata), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      issue(1'b0, 7'h7F, 8'h00, 1'b1, 1'b1, 8'h00, 1, 1'b1, 80,
            {8'b1111_1110, 1'b0, 8'b0000_0000, 1'b0, 1'b0}, 19, 1'b0, 8'h00);
      wait_done();
      repeat (3) @(negedge clk);
      cmp("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
